// File: rtl/lcd_message_sequencer_if.sv
// Handshake bundle between a pass requester and lcd_message_sequencer.
// master: drives start/msg_sel/drv_ready. slave: drives the LCD write port and status.
// IDX_W tracks the sequencer's character index width.
interface lcd_message_sequencer_if #(
  parameter int SEL_W     = 2,
  parameter int NUM_CHARS = 16
) ();
  localparam int IDX_W = $clog2(NUM_CHARS);

  logic [SEL_W-1:0] msg_sel;
  logic             start;
  logic             drv_ready;
  logic             wr_en;
  logic [7:0]       char_out;
  logic [IDX_W-1:0] char_idx;
  logic             busy;
  logic             done;

  modport master (
    output msg_sel, start, drv_ready,
    input  wr_en, char_out, char_idx, busy, done
  );

  modport slave (
    input  msg_sel, start, drv_ready,
    output wr_en, char_out, char_idx, busy, done
  );
endinterface

// File: rtl/lcd_message_sequencer.sv
// Paced streamer: writes every character of one ROM message to the LCD driver per pass.
// Latency: first strobe CLK_DIV+1 clocks after start; CLK_DIV+1 clocks between strobes.
// Backpressure: holds in ISSUE with no strobe while drv_ready=0. LCD_SEQ_REPEAT_EN: passes loop until reset.
module lcd_message_sequencer #(
  parameter int CLK_DIV   = 1600000,
  parameter int NUM_CHARS = 16,
  parameter int NUM_MSGS  = 4,
  parameter int SEL_W     = 2
) (
  input logic                    clk,
  input logic                    reset,
  lcd_message_sequencer_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_CHARS);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHARS - 1);
  localparam logic [SEL_W:0]   MSG_LIM  = (SEL_W+1)'(NUM_MSGS);

  typedef enum logic [1:0] {IDLE, PACE, ISSUE, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             wr_en_q, wr_en_d;
  logic [7:0]       char_out_q, char_out_d;
  logic [IDX_W-1:0] char_idx_q, char_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [SEL_W-1:0] sel_pick;

  // Out-of-range selections fall back to message 0.
  assign sel_pick = ({1'b0, bus.msg_sel} < MSG_LIM) ? bus.msg_sel : '0;

  // Fixed message ROM; everything past the five-letter words is space padding.
  function automatic logic [7:0] rom_char(input logic [SEL_W-1:0] s, input logic [IDX_W-1:0] i);
    logic [39:0] msg;
    logic [7:0]  c;
    case (int'(s))
      0:       msg = "HELLO";
      1:       msg = "HOWDY";
      2:       msg = "READY";
      3:       msg = "ERROR";
      default: msg = "     ";
    endcase
    case (int'(i))
      0:       c = msg[39:32];
      1:       c = msg[31:24];
      2:       c = msg[23:16];
      3:       c = msg[15:8];
      4:       c = msg[7:0];
      default: c = 8'h20;
    endcase
    return c;
  endfunction

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sel_d      = sel_q;
    wr_en_d    = 1'b0;
    char_out_d = char_out_q;
    char_idx_d = char_idx_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sel_d   = sel_pick;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = PACE;
        end
      end
      PACE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ISSUE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ISSUE: begin
        if (bus.drv_ready) begin
          wr_en_d    = 1'b1;
          char_out_d = rom_char(sel_q, idx_q);
          char_idx_d = idx_q;
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = PACE;
          end
        end
      end
      DONE: begin
        done_d = 1'b1;
`ifdef LCD_SEQ_REPEAT_EN
        sel_d   = sel_pick;
        idx_d   = '0;
        cnt_d   = '0;
        state_d = PACE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset wins over any pending start or strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      sel_q      <= '0;
      wr_en_q    <= 1'b0;
      char_out_q <= 8'h20;
      char_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      wr_en_q    <= wr_en_d;
      char_out_q <= char_out_d;
      char_idx_q <= char_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.char_out = char_out_q;
  assign bus.char_idx = char_idx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_lcd_message_sequencer.sv
// Randomized bench for lcd_message_sequencer against a timeline model of each pass.
// Model derives write edges arithmetically from start edge, pacing period and stalls.
// Build with LCD_SEQ_REPEAT_EN to exercise the looping variant instead.
module tb_lcd_message_sequencer;

  localparam int CLK_DIV   = 4;
  localparam int NUM_CHARS = 16;
  localparam int NUM_MSGS  = 4;
  localparam int SEL_W     = 3;
  localparam int PERIOD    = CLK_DIV + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lcd_message_sequencer_if #(.SEL_W(SEL_W), .NUM_CHARS(NUM_CHARS)) bus_if ();

  lcd_message_sequencer #(
    .CLK_DIV  (CLK_DIV),
    .NUM_CHARS(NUM_CHARS),
    .NUM_MSGS (NUM_MSGS),
    .SEL_W    (SEL_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] last_chr;
  int         last_idx;
  string      msgs [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_char(input int m, input int i);
    string s;
    s = msgs[m];
    if (i < s.len()) return s[i];
    return 8'h20;
  endfunction

  task automatic check_outputs(input bit exp_wr, input bit exp_done, input bit exp_busy);
    chk("wr_en", 32'(bus_if.wr_en), 32'(exp_wr));
    chk("char_out", 32'(bus_if.char_out), 32'(last_chr));
    chk("char_idx", 32'(bus_if.char_idx), 32'(last_idx));
    chk("done", 32'(bus_if.done), 32'(exp_done));
    chk("busy", 32'(bus_if.busy), 32'(exp_busy));
  endtask

  // One pass with an optional drv_ready stall on one character and an optional
  // mid-pass start/msg_sel disturbance that must be ignored.
  task automatic run_pass(input int sel, input int stall_char, input int stall_len,
                          input int dist_edge, input int dist_sel);
    int m, t, nom, stall_lo, d_edge;
    int w [NUM_CHARS];
    bit exp_wr;
    m = (sel < NUM_MSGS) ? sel : 0;
    t = 0;
    stall_lo = -100;
    for (int i = 0; i < NUM_CHARS; i++) begin
      nom = t + PERIOD;
      if (i == stall_char) begin
        stall_lo = nom;
        t = nom + stall_len;
      end else begin
        t = nom;
      end
      w[i] = t;
    end
    d_edge = w[NUM_CHARS-1] + 1;

    @(negedge clk);
    bus_if.msg_sel   = SEL_W'(sel);
    bus_if.start     = 1'b1;
    bus_if.drv_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    chk("busy_at_start", 32'(bus_if.busy), 32'd1);

    for (int e = 1; e <= d_edge + 1; e++) begin
      @(negedge clk);
      bus_if.drv_ready = !(e >= stall_lo && e < stall_lo + stall_len);
      bus_if.start     = (e == dist_edge);
      if (e == dist_edge) bus_if.msg_sel = SEL_W'(dist_sel);
      @(posedge clk); #1;
      exp_wr = 1'b0;
      for (int i = 0; i < NUM_CHARS; i++) begin
        if (w[i] == e) begin
          exp_wr   = 1'b1;
          last_chr = exp_char(m, i);
          last_idx = i;
        end
      end
      check_outputs(exp_wr, e == d_edge, e < d_edge);
    end
    bus_if.start     = 1'b0;
    bus_if.drv_ready = 1'b1;
  endtask

  // Reset lands just before (or on) the 8th write edge, together with a start.
  task automatic reset_mid(input int sel);
    int m, rst_edge;
    bit exp_wr;
    m = (sel < NUM_MSGS) ? sel : 0;
    rst_edge = 8 * PERIOD - 1 + int'($urandom_range(0, 1));
    @(negedge clk);
    bus_if.msg_sel = SEL_W'(sel);
    bus_if.start   = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    for (int e = 1; e <= rst_edge + 12; e++) begin
      @(negedge clk);
      reset        = (e == rst_edge);
      bus_if.start = (e == rst_edge);
      @(posedge clk); #1;
      exp_wr = 1'b0;
      if (e >= rst_edge) begin
        if (e == rst_edge) begin
          last_chr = 8'h20;
          last_idx = 0;
        end
        check_outputs(1'b0, 1'b0, 1'b0);
      end else begin
        if (e % PERIOD == 0) begin
          exp_wr   = 1'b1;
          last_chr = exp_char(m, e / PERIOD - 1);
          last_idx = e / PERIOD - 1;
        end
        check_outputs(exp_wr, 1'b0, 1'b1);
      end
    end
    reset        = 1'b0;
    bus_if.start = 1'b0;
  endtask

`ifdef LCD_SEQ_REPEAT_EN
  // Continuous passes: msg 1 first, msg_sel switched to 2 mid-pass for the next one.
  task automatic repeat_test();
    int k, m;
    bit exp_wr;
    @(negedge clk);
    bus_if.msg_sel = SEL_W'(1);
    bus_if.start   = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    for (int e = 1; e <= 2 * (NUM_CHARS * PERIOD + 1) + 8; e++) begin
      @(negedge clk);
      if (e == 40) bus_if.msg_sel = SEL_W'(2);
      @(posedge clk); #1;
      exp_wr = 1'b0;
      k = (e > NUM_CHARS * PERIOD + 1) ? e - (NUM_CHARS * PERIOD + 1) : e;
      m = (e > NUM_CHARS * PERIOD + 1) ? 2 : 1;
      if (k % PERIOD == 0 && k >= PERIOD && k <= NUM_CHARS * PERIOD) begin
        exp_wr   = 1'b1;
        last_chr = exp_char(m, k / PERIOD - 1);
        last_idx = k / PERIOD - 1;
      end
      check_outputs(exp_wr, (e == NUM_CHARS * PERIOD + 1) || (e == 2 * (NUM_CHARS * PERIOD + 1)), 1'b1);
    end
  endtask
`endif

  initial begin
    msgs[0] = "HELLO";
    msgs[1] = "HOWDY";
    msgs[2] = "READY";
    msgs[3] = "ERROR";
    last_chr = 8'h20;
    last_idx = 0;
    reset            = 1'b1;
    bus_if.start     = 1'b0;
    bus_if.msg_sel   = '0;
    bus_if.drv_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

`ifdef LCD_SEQ_REPEAT_EN
    repeat_test();
`else
    run_pass(0, -1, 0, -1, 0);
    run_pass(1, 2, 7, -1, 0);
    run_pass(1, -1, 0, 23, 0);
    reset_mid(2);
    run_pass(2, -1, 0, -1, 0);
    run_pass(7, -1, 0, -1, 0);
    for (int r = 0; r < 8; r++) begin
      run_pass(int'($urandom_range(0, 7)),
               ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, NUM_CHARS - 1)),
               int'($urandom_range(1, 9)),
               ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 70)),
               int'($urandom_range(0, 7)));
      repeat (int'($urandom_range(0, 3))) @(posedge clk);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
